// File: rtl/convolution_procesor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : convolution_procesor_pkg                                         |
// | Purpose : Shared types and helpers for the convolution result reader:      |
// |           read-out FSM state encoding and saturation limit functions.      |
// | Ports   : none (package)                                                   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package convolution_procesor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Largest value representable in a signed word of the given width.
  function automatic longint sat_max(input int width);
    return (longint'(1) << (width - 1)) - longint'(1);
  endfunction

  // Most negative value representable in a signed word of the given width.
  function automatic longint sat_min(input int width);
    return -(longint'(1) << (width - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/convolution_procesor_sat_fifo2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : convolution_procesor_sat_fifo2                                   |
// | Purpose : Two-entry output FIFO that narrows each incoming memory word to  |
// |           the output width with signed saturation as it is written.        |
// | Ports   : clk, rst_n        - clock, async active-low reset                |
// |           wr_en, wr_data    - push a DATA_WIDTH_M word                     |
// |           rd_en             - pop head (ignored when empty)                |
// |           rd_data, rd_sat   - head word and its saturation flag            |
// |           full, empty, count- occupancy status                             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module convolution_procesor_sat_fifo2
  import convolution_procesor_pkg::*;
#(
  parameter int DATA_WIDTH_M = 22,
  parameter int DATA_WIDTH_O = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH_M-1:0] wr_data,
  input  logic                    rd_en,
  output logic [DATA_WIDTH_O-1:0] rd_data,
  output logic                    rd_sat,
  output logic                    full,
  output logic                    empty,
  output logic [1:0]              count
);

  logic [DATA_WIDTH_O-1:0] w_wr_word;
  logic                    w_wr_sat;

  generate
    if (DATA_WIDTH_O < DATA_WIDTH_M) begin : g_sat
      localparam logic signed [DATA_WIDTH_M-1:0] C_SAT_HI = DATA_WIDTH_M'(sat_max(DATA_WIDTH_O));
      localparam logic signed [DATA_WIDTH_M-1:0] C_SAT_LO = DATA_WIDTH_M'(sat_min(DATA_WIDTH_O));
      always_comb begin
        w_wr_word = wr_data[DATA_WIDTH_O-1:0];
        w_wr_sat  = 1'b0;
        if ($signed(wr_data) > C_SAT_HI) begin
          w_wr_word = C_SAT_HI[DATA_WIDTH_O-1:0];
          w_wr_sat  = 1'b1;
        end else if ($signed(wr_data) < C_SAT_LO) begin
          w_wr_word = C_SAT_LO[DATA_WIDTH_O-1:0];
          w_wr_sat  = 1'b1;
        end
      end
    end else begin : g_pass
      // Equal widths: nothing can overflow, so the word passes straight through.
      assign w_wr_word = wr_data[DATA_WIDTH_O-1:0];
      assign w_wr_sat  = 1'b0;
    end
  endgenerate

  // Each slot holds {sat_flag, word}.
  logic [DATA_WIDTH_O:0] slot0_q, slot0_d, slot1_q, slot1_d;
  logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  w_push, w_pop;
  logic [DATA_WIDTH_O:0] w_head;

  always_comb begin
    w_push   = wr_en;
    w_pop    = rd_en && (count_q != 2'd0);
    slot0_d  = slot0_q;
    slot1_d  = slot1_q;
    if (w_push) begin
      if (wr_ptr_q) slot1_d = {w_wr_sat, w_wr_word};
      else          slot0_d = {w_wr_sat, w_wr_word};
    end
    wr_ptr_d = wr_ptr_q ^ w_push;
    rd_ptr_d = rd_ptr_q ^ w_pop;
    count_d  = count_q + {1'b0, w_push} - {1'b0, w_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q  <= '0;
      slot1_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      slot0_q  <= slot0_d;
      slot1_q  <= slot1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign w_head  = rd_ptr_q ? slot1_q : slot0_q;
  assign rd_data = w_head[DATA_WIDTH_O-1:0];
  assign rd_sat  = w_head[DATA_WIDTH_O];
  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign count   = count_q;

endmodule
`default_nettype wire

// File: rtl/convolution_procesor_result_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : convolution_procesor_result_reader                               |
// | Purpose : Reads accumulated results from the result RAM and streams them   |
// |           out over valid/ready, saturated to the output width.             |
// | Ports   : clk, rst_n                    - clock, async active-low reset    |
// |           start, length, base_addr      - read-out request                 |
// |           mem_rd_en/addr, mem_rd_data   - result RAM read port (1-cycle)   |
// |           data_out, sat_flag, data_valid, data_ready - output stream       |
// |           busy, done                    - status                           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module convolution_procesor_result_reader
  import convolution_procesor_pkg::*;
#(
  parameter int DATA_WIDTH_M = 22,
  parameter int DATA_WIDTH_O = 16,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH:0]     length,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
  input  logic [DATA_WIDTH_M-1:0] mem_rd_data,
  output logic [DATA_WIDTH_O-1:0] data_out,
  output logic                    data_valid,
  input  logic                    data_ready,
  output logic                    sat_flag,
  output logic                    busy,
  output logic                    done
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  pend_q, pend_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic       w_full, w_empty, w_pop, w_room, w_issue;
  logic [1:0] w_count;

  assign w_pop = !w_empty && data_ready;

  // A new read lands in the buffer one cycle after it is issued, so it may go
  // out only if entries held plus the read already in flight, less the word
  // leaving this cycle, still leave a free slot.
  always_comb begin
    if (pend_q) w_room = (w_count == 2'd0) || ((w_count == 2'd1) && w_pop);
    else        w_room = !w_full || w_pop;
  end

  assign w_issue = (state_q == ST_READ) && w_room;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pend_d  = w_issue;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d   = length;
          addr_d  = base_addr;
          busy_d  = 1'b1;
          state_d = (length == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (w_issue) begin
          addr_d = addr_q + 1'b1;  // wraps naturally at 2^ADDR_WIDTH
          rem_d  = rem_q - 1'b1;
          if (rem_q == (ADDR_WIDTH+1)'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_empty && !pend_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      addr_q  <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  convolution_procesor_sat_fifo2 #(
    .DATA_WIDTH_M (DATA_WIDTH_M),
    .DATA_WIDTH_O (DATA_WIDTH_O)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (pend_q),
    .wr_data (mem_rd_data),
    .rd_en   (data_ready),
    .rd_data (data_out),
    .rd_sat  (sat_flag),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  assign mem_rd_en   = w_issue;
  assign mem_rd_addr = addr_q;
  assign data_valid  = !w_empty;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
`default_nettype wire
